// File: rtl/muxn_pkg.sv
// muxn_pkg: shared state encoding and default sizes for the muxn selector family
package muxn_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM_IN = 4;
endpackage

// File: rtl/muxn_comb.sv
// muxn_comb: combinational N:1 selector with out-of-range select detect
module muxn_comb #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] OOR_VALUE = '0
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    oor_o
);
  localparam logic [SEL_W:0] N = NUM_IN[SEL_W:0];
  assign oor_o = {1'b0, sel_i} >= N;
  always_comb begin
    data_o = OOR_VALUE;
    for (int k = 0; k < NUM_IN; k++)
      if (sel_i == SEL_W'(k)) data_o = data_i[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/muxn_skid.sv
// muxn_skid: N:1 selector feeding a 2-entry skid buffer with valid/ready, flush and sticky OOR flag
module muxn_skid import muxn_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] OOR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    err_oor,
  input  logic                    err_clr
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, sel_val;
  logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic err_q, err_d, oor, in_fire, out_fire;
  muxn_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .OOR_VALUE(OOR_VALUE)) u_comb (
    .data_i(in_data), .sel_i(in_sel), .data_o(sel_val), .oor_o(oor)
  );
  assign in_ready = !reset && !flush && state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = main_data_q;
  assign out_sel = main_sel_q;
  assign err_oor = err_q;
  always_comb begin
    state_d = state_q;
    main_data_d = main_data_q;
    main_sel_d = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d = skid_sel_q;
    err_d = (in_fire && oor) ? 1'b1 : err_clr ? 1'b0 : err_q;
    // flush drops entries but leaves the last output word visible
    if (flush) state_d = EMPTY;
    else
      unique case (state_q)
        EMPTY: if (in_fire) begin
          main_data_d = sel_val;
          main_sel_d = in_sel;
          state_d = ONE;
        end
        ONE: if (in_fire && out_fire) begin
          main_data_d = sel_val;
          main_sel_d = in_sel;
        end else if (in_fire) begin
          skid_data_d = sel_val;
          skid_sel_d = in_sel;
          state_d = FULL;
        end else if (out_fire) state_d = EMPTY;
        FULL: if (out_fire) begin
          main_data_d = skid_data_q;
          main_sel_d = skid_sel_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_data_q <= '0;
      main_sel_q <= '0;
      skid_data_q <= '0;
      skid_sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_data_q <= main_data_d;
      main_sel_q <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q <= skid_sel_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_muxn_skid.sv
// tb_muxn_skid: scoreboard bench driving a 4-input and a 3-input muxn_skid with shared stimulus
module tb_muxn_skid;
  typedef struct {logic [31:0] d; logic [1:0] s;} ent_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, flush = 0, err_clr = 0;
  logic [1:0] in_sel = 0;
  logic [31:0] w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [127:0] in_data;
  logic rdy4, ov4, err4, rdy3, ov3, err3;
  logic [31:0] od4, od3;
  logic [1:0] os4, os3;
  ent_t q4 [$], q3 [$];
  int tests = 0, fails = 0;
  assign in_data = {w[3], w[2], w[1], w[0]};
  always #5 clk = ~clk;
  muxn_skid #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .OOR_VALUE(32'h0)) d4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy4), .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(out_ready),
    .flush(flush), .err_oor(err4), .err_clr(err_clr));
  muxn_skid #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .OOR_VALUE(32'h0)) d3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy3), .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(out_ready),
    .flush(flush), .err_oor(err3), .err_clr(err_clr));
  function automatic logic [31:0] expv(int n, logic [1:0] s);
    return (int'(s) < n) ? w[s] : 32'h0;
  endfunction
  task automatic chk(string n, logic [33:0] got, logic [33:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic pop(string n, ref ent_t q [$], input logic [31:0] d, input logic [1:0] s);
    ent_t e;
    if (q.size() == 0) chk({n, " unexpected output"}, {s, d}, 34'h0);
    else begin
      e = q.pop_front();
      chk(n, {s, d}, {e.s, e.d});
    end
  endtask
  always @(negedge clk) begin
    if (ov4 && out_ready) pop("out4", q4, od4, os4);
    if (ov3 && out_ready) pop("out3", q3, od3, os3);
    if (reset || flush) begin
      q4.delete();
      q3.delete();
    end else begin
      if (in_valid && rdy4) q4.push_back('{expv(4, in_sel), in_sel});
      if (in_valid && rdy3) q3.push_back('{expv(3, in_sel), in_sel});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc();
    cyc();
    #1;
    chk("reset ov", ov4, 0);
    chk("reset od", od4, 0);
    chk("reset os", os4, 0);
    chk("reset err", err3, 0);
    chk("reset rdy", rdy4, 0);
    reset = 0;
    #1 chk("rdy after reset", rdy4, 1);
    // basic path
    in_sel = 2; in_valid = 1; out_ready = 1;
    cyc(); in_valid = 0;
    #1 chk("basic ov", ov4, 1);
    chk("basic od", od4, 32'h33333333);
    chk("basic os", os4, 2);
    cyc(); #1 chk("basic ov drop", ov4, 0);
    // backpressure
    out_ready = 0; in_sel = 0; in_valid = 1;
    cyc(); in_sel = 1;
    #1 chk("bp rdy one", rdy4, 1);
    cyc(); in_valid = 0;
    #1 chk("bp rdy full", rdy4, 0);
    chk("bp hold", od4, 32'h11111111);
    cyc(); #1 chk("bp hold2", od4, 32'h11111111);
    out_ready = 1;
    cyc(); #1 chk("bp second", od4, 32'h22222222);
    chk("bp rdy back", rdy4, 1);
    cyc(); #1 chk("bp empty", ov4, 0);
    // streaming
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 2'(i);
      cyc();
      #1 chk("stream ov", ov4, 1);
      chk("stream rdy", rdy4, 1);
    end
    in_valid = 0;
    cyc(); #1 chk("stream drained", ov4, 0);
    // out-of-range select on the 3-input instance
    err_clr = 1;
    cyc(); err_clr = 0;
    #1 chk("err cleared", err3, 0);
    in_sel = 3; in_valid = 1;
    cyc(); in_valid = 0;
    #1 chk("oor data", od3, 0);
    chk("oor err3", err3, 1);
    chk("pow2 err4", err4, 0);
    cyc(); #1 chk("oor sticky", err3, 1);
    err_clr = 1; in_valid = 1;
    cyc(); err_clr = 0; in_valid = 0;
    #1 chk("set wins", err3, 1);
    err_clr = 1;
    cyc(); err_clr = 0;
    #1 chk("err clr", err3, 0);
    // flush while full
    out_ready = 0; in_sel = 0; in_valid = 1;
    cyc(); in_sel = 1;
    cyc(); in_sel = 2; flush = 1;
    #1 chk("flush rdy", rdy4, 0);
    cyc(); flush = 0; in_valid = 0;
    #1 chk("flush ov", ov4, 0);
    chk("flush rdy after", rdy4, 1);
    chk("flush hold od", od4, 32'h11111111);
    chk("flush hold os", os4, 0);
    in_sel = 3; in_valid = 1; out_ready = 1;
    cyc(); in_valid = 0;
    #1 chk("post flush od", od4, 32'h44444444);
    cyc(); #1 chk("post flush alone", ov4, 0);
    // reset mid-operation
    out_ready = 0; in_sel = 3; in_valid = 1;
    cyc();
    cyc(); in_valid = 0;
    #1 chk("pre-rst full", rdy4, 0);
    chk("pre-rst err", err3, 1);
    reset = 1;
    cyc(); #1 chk("rst ov", ov3, 0);
    chk("rst od", od4, 0);
    chk("rst os", os3, 0);
    chk("rst err", err3, 0);
    chk("rst rdy held", rdy4, 0);
    reset = 0;
    #1 chk("rst rdy rel", rdy4, 1);
    cyc();
    chk("q4 empty", 34'(q4.size()), 0);
    chk("q3 empty", 34'(q3.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
